// File: rtl/prog_loader.sv
// ============================================================================
// prog_loader
// ----------------------------------------------------------------------------
// Serial program loader. An external host frames a transfer with spi_cs_n
// and clocks bits in on spi_mosi (MSB first, sampled on spi_sck rising).
// The first byte of a frame is a header: upper nibble 4'hA marks a valid
// load and the lower nibble is the start address. Every following complete
// byte is written into the downstream instruction memory at consecutive
// addresses. The serial inputs are asynchronous to clk and pass through
// synchronizers. clk must run at least 4x faster than spi_sck.
//
// Parameters
//   ADDR_WIDTH   instruction-memory address width
//   DATA_WIDTH   instruction width / serial shift length
//   SYNC_STAGES  synchronizer depth on each serial input (must be >= 2)
//
// Ports
//   clk          system clock, rising-edge active
//   rst_n        asynchronous active-low reset
//   spi_cs_n     frame select from host, active low (asynchronous)
//   spi_sck      serial clock from host (asynchronous)
//   spi_mosi     serial data, MSB first (asynchronous)
//   wr_en        one-cycle instruction-memory write strobe
//   wr_addr      write address, valid with wr_en
//   wr_data      write data, valid with wr_en
//   load_active  high while a frame is in progress
//   load_done    one-cycle pulse at the end of a frame that wrote words
//                without error
//   load_err     sticky error flag, cleared when the next frame starts
//   word_count   words written in the current or last frame
// ============================================================================
module prog_loader #(
    parameter int ADDR_WIDTH  = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  spi_cs_n,
    input  logic                  spi_sck,
    input  logic                  spi_mosi,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  load_active,
    output logic                  load_done,
    output logic                  load_err,
    output logic [ADDR_WIDTH:0]   word_count
);

    localparam int              BCNT_W    = $clog2(DATA_WIDTH);
    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(DATA_WIDTH - 1);
    localparam logic [3:0]      HDR_TAG   = 4'hA;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEADER  = 2'd1,
        DATA    = 2'd2,
        DISCARD = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizers
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES-1:0] sync_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_sync   <= '1;
            sck_sync  <= '0;
            mosi_sync <= '0;
            sync_vld  <= '0;
        end else begin
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0],   spi_cs_n};
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0],  spi_sck};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            sync_vld  <= {sync_vld[SYNC_STAGES-2:0],  1'b1};
        end
    end

    logic cs_s;
    logic sck_s;
    logic mosi_s;

    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign sck_s  = sck_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Stage p0: edge detection on the synchronized signals
    // ------------------------------------------------------------------
    // armed stays low after reset until cs_n has genuinely been seen high,
    // so a frame already running when reset released is ignored and the
    // reset value of the cs_n synchronizer cannot fake a falling edge.
    logic armed;
    logic cs_last;
    logic sck_last;
    logic rise_vld_p0;
    logic cs_fall_p0;
    logic cs_rise_p0;
    logic mosi_p0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed       <= 1'b0;
            cs_last     <= 1'b1;
            sck_last    <= 1'b0;
            rise_vld_p0 <= 1'b0;
            cs_fall_p0  <= 1'b0;
            cs_rise_p0  <= 1'b0;
        end else begin
            armed       <= armed | (sync_vld[SYNC_STAGES-1] & cs_s);
            cs_last     <= cs_s;
            sck_last    <= sck_s;
            // An sck edge landing in the same cycle cs_n rises is dropped:
            // cs_s is already high, so the frame end wins.
            rise_vld_p0 <= armed & ~cs_s & sck_s & ~sck_last;
            cs_fall_p0  <= armed & cs_last & ~cs_s;
            cs_rise_p0  <= armed & ~cs_last & cs_s;
        end
    end

    always_ff @(posedge clk) begin
        mosi_p0 <= mosi_s;
    end

    // ------------------------------------------------------------------
    // Stage p1: bit assembly
    // ------------------------------------------------------------------
    logic [BCNT_W-1:0]     bit_cnt;
    logic                  byte_vld_p1;
    logic                  cs_fall_p1;
    logic                  cs_rise_p1;
    logic [DATA_WIDTH-1:0] shift_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt     <= '0;
            byte_vld_p1 <= 1'b0;
            cs_fall_p1  <= 1'b0;
            cs_rise_p1  <= 1'b0;
        end else begin
            byte_vld_p1 <= 1'b0;
            cs_fall_p1  <= cs_fall_p0;
            cs_rise_p1  <= cs_rise_p0;
            if (cs_fall_p0) begin
                bit_cnt <= '0;
            end else if (rise_vld_p0) begin
                if (bit_cnt == BCNT_LAST) begin
                    bit_cnt     <= '0;
                    byte_vld_p1 <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + BCNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (cs_fall_p0) begin
            shift_p1 <= '0;
        end else if (rise_vld_p0) begin
            shift_p1 <= {shift_p1[DATA_WIDTH-2:0], mosi_p0};
        end
    end

    logic [3:0]            hdr_tag;
    logic [ADDR_WIDTH-1:0] hdr_addr;

    assign hdr_tag  = shift_p1[DATA_WIDTH-1 -: 4];
    assign hdr_addr = shift_p1[ADDR_WIDTH-1:0];

    // ------------------------------------------------------------------
    // Stage p2: frame FSM and registered memory-write outputs
    // ------------------------------------------------------------------
    state_t                state, state_n;
    logic [ADDR_WIDTH-1:0] cur_addr, addr_n;
    logic                  addr_full, full_n;
    logic [ADDR_WIDTH:0]   count_n;
    logic                  err_n;
    logic                  wr_en_n;
    logic [ADDR_WIDTH-1:0] wr_addr_n;
    logic [DATA_WIDTH-1:0] wr_data_n;
    logic                  done_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cur_addr   <= '0;
            addr_full  <= 1'b0;
            word_count <= '0;
            load_err   <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            load_done  <= 1'b0;
        end else begin
            state      <= state_n;
            cur_addr   <= addr_n;
            addr_full  <= full_n;
            word_count <= count_n;
            load_err   <= err_n;
            wr_en      <= wr_en_n;
            wr_addr    <= wr_addr_n;
            wr_data    <= wr_data_n;
            load_done  <= done_n;
        end
    end

    always_comb begin
        state_n   = state;
        addr_n    = cur_addr;
        full_n    = addr_full;
        count_n   = word_count;
        err_n     = load_err;
        wr_en_n   = 1'b0;
        wr_addr_n = wr_addr;
        wr_data_n = wr_data;
        done_n    = 1'b0;

        if (state != IDLE && cs_rise_p1) begin
            // Frame end takes priority; any partial byte is simply dropped
            // and wr_en_n stays low so no write coincides with the exit.
            state_n = IDLE;
            done_n  = (word_count != '0) && !load_err;
        end else begin
            unique case (state)
                IDLE: begin
                    if (cs_fall_p1) begin
                        state_n = HEADER;
                        addr_n  = '0;
                        full_n  = 1'b0;
                        count_n = '0;
                        err_n   = 1'b0;
                    end
                end
                HEADER: begin
                    if (byte_vld_p1) begin
                        if (hdr_tag == HDR_TAG) begin
                            state_n = DATA;
                            addr_n  = hdr_addr;
                        end else begin
                            state_n = DISCARD;
                            err_n   = 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (byte_vld_p1) begin
                        if (addr_full) begin
                            // Top address already written: refuse to wrap.
                            state_n = DISCARD;
                            err_n   = 1'b1;
                        end else begin
                            wr_en_n   = 1'b1;
                            wr_addr_n = cur_addr;
                            wr_data_n = shift_p1;
                            count_n   = word_count + (ADDR_WIDTH + 1)'(1);
                            if (&cur_addr) begin
                                full_n = 1'b1;
                            end else begin
                                addr_n = cur_addr + ADDR_WIDTH'(1);
                            end
                        end
                    end
                end
                DISCARD: begin
                    state_n = DISCARD;
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    assign load_active = (state != IDLE);

endmodule

// File: tb/tb_prog_loader.sv
// ============================================================================
// tb_prog_loader
// ----------------------------------------------------------------------------
// Self-checking bench for prog_loader. Frames are generated at the serial
// pin level; a frame-level reference model predicts the memory writes and
// end-of-frame status, pushes expected writes and load_done pulses into a
// scoreboard, and a monitor process pops them as the DUT presents them.
// ============================================================================
module tb_prog_loader;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int SS = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          spi_cs_n;
    logic          spi_sck;
    logic          spi_mosi;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          load_active;
    logic          load_done;
    logic          load_err;
    logic [AW:0]   word_count;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [11:0]   exp_q[$];
    int            exp_done = 0;
    logic [7:0]    data_buf[0:31];
    logic [11:0]   mon_e;

    always #5 clk = ~clk;

    prog_loader #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .SYNC_STAGES(SS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .spi_cs_n   (spi_cs_n),
        .spi_sck    (spi_sck),
        .spi_mosi   (spi_mosi),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .load_active(load_active),
        .load_done  (load_done),
        .load_err   (load_err),
        .word_count (word_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every write and every load_done pulse must have
    // been predicted by the model.
    always @(negedge clk) begin
        if (wr_en) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL wr_unexpected: got write addr 0x%0h data 0x%0h, required no write (t=%0t)",
                         wr_addr, wr_data, $time);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_addr_data", {20'd0, wr_addr, wr_data}, {20'd0, mon_e});
            end
            chk("wr_with_active", {31'd0, load_active}, 32'd1);
        end
        if (load_done) begin
            if (exp_done == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL done_unexpected: got load_done=1, required 0 (t=%0t)", $time);
            end else begin
                exp_done--;
                chk("done_pulse", 32'd1, {31'd0, load_done});
            end
        end
    end

    // Keeps stimulus times away from the active clock edge.
    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
        #2;
    endtask

    task automatic send_bits(input logic [7:0] b, input int nbits, input int half);
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = b[7-i];
            #(half);
            spi_sck = 1'b1;
            #(half);
            spi_sck = 1'b0;
        end
    endtask

    task automatic check_idle_result(input string tag, input int cnt, input logic err);
        chk({tag, "_word_count"}, {27'd0, word_count}, cnt);
        chk({tag, "_load_err"}, {31'd0, load_err}, {31'd0, err});
        chk({tag, "_load_active"}, {31'd0, load_active}, 32'd0);
        chk({tag, "_writes_pending"}, exp_q.size(), 32'd0);
        chk({tag, "_done_pending"}, exp_done, 32'd0);
    endtask

    // Frame-level reference: a header with tag 0xA starts writing at its
    // low nibble; each byte goes to the next address until address 15 has
    // been used, after which the next byte is an error and nothing more is
    // written. load_done only for an error-free frame with writes.
    task automatic run_frame(input string tag, input logic [7:0] hdr, input int nbytes,
                             input int partial, input int half);
        int   addr;
        int   cnt;
        logic err;
        err  = (hdr[7:4] != 4'hA);
        cnt  = 0;
        addr = int'(hdr[3:0]);
        if (!err) begin
            for (int i = 0; i < nbytes; i++) begin
                if (addr > 15) begin
                    err = 1'b1;
                    break;
                end
                exp_q.push_back({4'(addr), data_buf[i]});
                addr++;
                cnt++;
            end
        end
        if (!err && cnt > 0) exp_done++;

        spi_cs_n = 1'b0;
        #100;
        chk({tag, "_start_active"}, {31'd0, load_active}, 32'd1);
        chk({tag, "_start_err_clear"}, {31'd0, load_err}, 32'd0);
        send_bits(hdr, 8, half);
        for (int i = 0; i < nbytes; i++) send_bits(data_buf[i], 8, half);
        if (partial > 0) send_bits(8'($urandom), partial, half);
        #(half);
        spi_cs_n = 1'b1;
        wait_clks(10);
        check_idle_result(tag, cnt, err);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: time limit reached, required test completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] lat_byte;
        int         lat;
        int         half;
        int         nib;
        logic [7:0] hdr;

        rst_n    = 1'b1;
        spi_cs_n = 1'b1;
        spi_sck  = 1'b0;
        spi_mosi = 1'b0;
        #7;
        rst_n = 1'b0;
        #1;
        chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
        chk("rst_wr_addr", {28'd0, wr_addr}, 32'd0);
        chk("rst_wr_data", {24'd0, wr_data}, 32'd0);
        chk("rst_load_active", {31'd0, load_active}, 32'd0);
        chk("rst_load_done", {31'd0, load_done}, 32'd0);
        chk("rst_load_err", {31'd0, load_err}, 32'd0);
        chk("rst_word_count", {27'd0, word_count}, 32'd0);
        wait_clks(3);
        rst_n = 1'b1;
        wait_clks(10);

        // Basic two-byte load
        data_buf[0] = 8'h41;
        data_buf[1] = 8'h52;
        run_frame("basic", 8'hA3, 2, 0, 40);

        // Bad header
        data_buf[0] = 8'($urandom);
        data_buf[1] = 8'($urandom);
        run_frame("bad_hdr", 8'h5F, 2, 0, 30);

        // Address exhaustion
        for (int i = 0; i < 17; i++) data_buf[i] = 8'($urandom);
        run_frame("overflow", 8'hA0, 17, 0, 30);

        // Partial trailing byte
        data_buf[0] = 8'($urandom);
        run_frame("partial", 8'hA7, 1, 5, 40);

        // Error frame followed by a good frame
        data_buf[0] = 8'($urandom);
        run_frame("err_then", 8'h5F, 1, 3, 30);
        data_buf[0] = 8'hFF;
        run_frame("recover", 8'hA1, 1, 0, 30);

        // Reset in the middle of a frame
        for (int i = 0; i < 5; i++) data_buf[i] = 8'($urandom);
        for (int i = 0; i < 3; i++) exp_q.push_back({4'(i), data_buf[i]});
        spi_cs_n = 1'b0;
        #100;
        send_bits(8'hA0, 8, 30);
        for (int i = 0; i < 3; i++) send_bits(data_buf[i], 8, 30);
        send_bits(data_buf[3], 4, 30);
        rst_n = 1'b0;
        #1;
        chk("midrst_wr_en", {31'd0, wr_en}, 32'd0);
        chk("midrst_wr_addr", {28'd0, wr_addr}, 32'd0);
        chk("midrst_wr_data", {24'd0, wr_data}, 32'd0);
        chk("midrst_load_active", {31'd0, load_active}, 32'd0);
        chk("midrst_load_done", {31'd0, load_done}, 32'd0);
        chk("midrst_load_err", {31'd0, load_err}, 32'd0);
        chk("midrst_word_count", {27'd0, word_count}, 32'd0);
        chk("midrst_writes_before", exp_q.size(), 32'd0);
        wait_clks(2);
        rst_n = 1'b1;
        wait_clks(4);
        send_bits(data_buf[3], 8, 30);
        send_bits(data_buf[4], 8, 30);
        #30;
        chk("midrst_ignored_active", {31'd0, load_active}, 32'd0);
        spi_cs_n = 1'b1;
        wait_clks(10);
        check_idle_result("midrst_end", 0, 1'b0);
        data_buf[0] = 8'($urandom);
        data_buf[1] = 8'($urandom);
        run_frame("after_rst", 8'hA2, 2, 0, 40);

        // Write latency from the first clk edge that sees sck high
        lat_byte = 8'($urandom);
        exp_q.push_back({4'd5, lat_byte});
        exp_done++;
        spi_cs_n = 1'b0;
        #100;
        send_bits(8'hA5, 8, 30);
        send_bits(lat_byte, 7, 30);
        spi_mosi = lat_byte[0];
        #30;
        @(posedge clk);
        #2;
        spi_sck = 1'b1;
        @(posedge clk);
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            if (wr_en && lat == 0) lat = k;
        end
        chk("wr_latency", lat, SS + 2);
        spi_sck = 1'b0;
        wait_clks(1);
        #30;
        spi_cs_n = 1'b1;
        wait_clks(10);
        check_idle_result("latency", 1, 1'b0);

        // Randomized frames
        for (int f = 0; f < 25; f++) begin
            half = 10 * $urandom_range(3, 5);
            if ($urandom_range(0, 3) != 0) begin
                hdr = {4'hA, 4'($urandom_range(0, 15))};
            end else begin
                nib = $urandom_range(0, 14);
                if (nib >= 10) nib++;
                hdr = {4'(nib), 4'($urandom)};
            end
            for (int i = 0; i < 19; i++) data_buf[i] = 8'($urandom);
            run_frame("rand", hdr, $urandom_range(0, 18), $urandom_range(0, 7), half);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter ADDR_WIDTH, default 4, SHALL set the instruction-memory address width (16 locations).
REQ-002 Parameter DATA_WIDTH, default 8, SHALL set the instruction width and the serial shift length.
REQ-003 Parameter SYNC_STAGES, default 2, SHALL set the synchronizer depth on each serial input.
REQ-004 clk  input  1  the single system clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 spi_cs_n  input  1  frame select from the external host, active low, asynchronous to clk.
REQ-007 spi_sck  input  1  serial clock from the host; data is sampled on its rising edge; asynchronous to clk.
REQ-008 spi_mosi  input  1  serial data, MSB first.
REQ-009 wr_en  output  1  one-cycle instruction-memory write strobe to the downstream core.
REQ-010 wr_addr  output  ADDR_WIDTH  write address, valid while wr_en=1.
REQ-011 wr_data  output  DATA_WIDTH  write data, valid while wr_en=1.
REQ-012 load_active  output  1  high while a frame is in progress; holds the core out of execution.
REQ-013 load_done  output  1  one-cycle pulse at the end of a frame that wrote at least one word.
REQ-014 load_err  output  1  sticky error flag; cleared at the start of the next frame.
REQ-015 word_count  output  ADDR_WIDTH+1  number of words written in the current or last frame.

Function
REQ-016 spi_cs_n, spi_sck and spi_mosi SHALL each pass through SYNC_STAGES flops; sck rising edge SHALL be detected from the synchronized sck only; clk SHALL be at least 4x the sck frequency.
REQ-017 FSM states SHALL be IDLE, HEADER, DATA, DISCARD.
REQ-018 IDLE -> HEADER on synchronized cs_n falling; bit counter, shift register and word_count cleared; load_err cleared.
REQ-019 HEADER SHALL shift 8 bits; a header byte whose upper nibble is 4'hA SHALL load its lower nibble as start address and enter DATA; any other value SHALL set load_err and enter DISCARD.
REQ-020 DATA: each 8th shifted bit SHALL produce wr_en=1 for exactly one cycle with wr_data = assembled byte and wr_addr = current address, then address += 1 and word_count += 1.
REQ-021 wr_en SHALL assert exactly SYNC_STAGES+2 clk cycles after the clk edge that first samples spi_sck high for the 8th bit.
REQ-022 After the write to address 15, the address SHALL NOT wrap; the next completed byte SHALL set load_err, produce no write, and enter DISCARD.
REQ-023 DISCARD SHALL ignore all sck edges until cs_n deasserts.
REQ-024 Synchronized cs_n rising from any non-IDLE state SHALL return to IDLE on the next cycle; a partial byte SHALL be discarded with no write.
REQ-025 load_done SHALL pulse for one cycle on that return iff word_count > 0 and load_err=0.
REQ-026 load_active SHALL be 1 in HEADER, DATA, DISCARD and 0 in IDLE.
REQ-027 sck edges while cs_n is high SHALL be ignored; a cs_n rise and sck edge in the same cycle SHALL resolve as frame end (the edge is ignored).
REQ-028 wr_en SHALL never assert in the cycle load_active falls.

Reset
REQ-029 On rst_n low, asynchronously: state=IDLE, wr_en=0, wr_addr=0, wr_data=0, load_active=0, load_done=0, load_err=0, word_count=0, synchronizer flops=1 for cs_n, 0 for sck/mosi.
REQ-030 Reset mid-frame SHALL abandon the frame with no further writes; after release, a frame already in progress SHALL be ignored until cs_n is seen high.

Verification
REQ-031 Header 0xA3, bytes 0x41,0x52 -> wr_en pulses at addr 3 data 0x41, addr 4 data 0x52; word_count=2; one load_done after cs_n rise.
REQ-032 Header 0x5F -> load_err=1, no wr_en, load_active high until cs_n rise, no load_done.
REQ-033 Header 0xA0 then 17 bytes -> 16 writes addr 0..15, 17th byte sets load_err, no write, no load_done.
REQ-034 Header 0xA7, one byte, then 5 bits and cs_n rise -> single write at addr 7, partial byte dropped, load_done pulses, word_count=1.
REQ-035 rst_n low after 3 data bytes mid-frame -> all outputs at reset values immediately; no write until a new cs_n fall.
REQ-036 Error frame followed by valid frame header 0xA1 byte 0xFF -> load_err clears at cs_n fall, write addr 1 data 0xFF, load_done pulses.
